// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request, one-entry skid buffer, and the IF/ID register.
// Define FETCH_STALL_CNT_EN to add a saturating stall-cycle counter on stall_cnt_o.
module instr_fetch (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_inc;
  logic [31:0] instr_q, ifid_pc_q, ifid_pc4_q;
  logic        valid_q;
  logic [31:0] skid_instr_q, skid_pc_q, skid_pc4_q;
  logic        load_fetch, load_skid, capture_skid, drop_valid;

  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Redirects win over everything; otherwise the fetch/hold handshake decides.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load_fetch   = 1'b0;
    load_skid    = 1'b0;
    capture_skid = 1'b0;
    drop_valid   = 1'b0;
    if (flush_i) begin
      state_d    = FETCH;
      drop_valid = 1'b1;
    end else if (branch_i) begin
      state_d    = FETCH;
      pc_d       = branch_target_i;
      drop_valid = 1'b1;
    end else if (jump_i) begin
      state_d    = FETCH;
      pc_d       = {ifid_pc4_q[31:28], jump_target_i, 2'b00};
      drop_valid = 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready_i) begin
            pc_d = pc_inc;
            if (stall_i) begin
              capture_skid = 1'b1;
              state_d      = HOLD;
            end else begin
              load_fetch = 1'b1;
            end
          end else if (!stall_i) begin
            drop_valid = 1'b1;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            load_skid = 1'b1;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q    <= 32'd0;
      ifid_pc_q  <= 32'd0;
      ifid_pc4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else if (load_fetch) begin
      instr_q    <= imem_data_i;
      ifid_pc_q  <= pc_q;
      ifid_pc4_q <= pc_inc;
      valid_q    <= 1'b1;
    end else if (load_skid) begin
      instr_q    <= skid_instr_q;
      ifid_pc_q  <= skid_pc_q;
      ifid_pc4_q <= skid_pc4_q;
      valid_q    <= 1'b1;
    end else if (drop_valid) begin
      valid_q    <= 1'b0;
    end
  end

  // Skid contents only matter while in HOLD, so no explicit valid bit is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      skid_pc4_q   <= 32'd0;
    end else if (capture_skid) begin
      skid_instr_q <= imem_data_i;
      skid_pc_q    <= pc_q;
      skid_pc4_q   <= pc_inc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_i && valid_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

  assign imem_req_o  = (state_q == FETCH) && !rst_i;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign instr_op_o  = instr_q[31:26];
  assign pc_o        = ifid_pc_q;
  assign pc_plus4_o  = ifid_pc4_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the fetch stage.
module tb_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_data_i = 32'd0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        jump_i = 1'b0;
  logic [25:0] jump_target_i = 26'd0;
  logic [31:0] instr_o;
  logic [5:0]  instr_op_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic [15:0] stall_cnt_o;

  instr_fetch dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_data_i     (imem_data_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .instr_o         (instr_o),
    .instr_op_o      (instr_op_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Model: next fetch address, words accepted but not yet handed to decode,
  // and what decode currently sees.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } word_t;

  word_t       held[$];
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    held.delete();
    m_pc    = 32'd0;
    m_valid = 1'b0;
    m_instr = 32'd0;
    m_pcout = 32'd0;
    m_cnt   = 16'd0;
  endtask

  task automatic modelStep();
    word_t       w;
    logic [31:0] seq;
    if (stall_i && m_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (flush_i) begin
      m_valid = 1'b0;
      held.delete();
    end else if (branch_i) begin
      m_pc    = branch_target_i;
      m_valid = 1'b0;
      held.delete();
    end else if (jump_i) begin
      seq     = m_pcout + 32'd4;
      m_pc    = {seq[31:28], jump_target_i, 2'b00};
      m_valid = 1'b0;
      held.delete();
    end else if (held.size() != 0) begin
      if (!stall_i) begin
        w       = held.pop_front();
        m_instr = w.instr;
        m_pcout = w.pc;
        m_valid = 1'b1;
      end
    end else if (imem_ready_i) begin
      if (stall_i) begin
        w.instr = imem_data_i;
        w.pc    = m_pc;
        held.push_back(w);
      end else begin
        m_instr = imem_data_i;
        m_pcout = m_pc;
        m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall_i) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [15:0] expCnt();
`ifdef FETCH_STALL_CNT_EN
    return m_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic checkOutput();
    check("imem_req", {31'd0, imem_req_o}, {31'd0, held.size() == 0});
    if (held.size() == 0) check("imem_addr", imem_addr_o, m_pc);
    check("valid", {31'd0, valid_o}, {31'd0, m_valid});
    if (m_valid) begin
      check("instr", instr_o, m_instr);
      check("instr_op", {26'd0, instr_op_o}, {26'd0, m_instr[31:26]});
      check("pc", pc_o, m_pcout);
      check("pc_plus4", pc_plus4_o, m_pcout + 32'd4);
    end
    check("stall_cnt", {16'd0, stall_cnt_o}, {16'd0, expCnt()});
  endtask

  task automatic applyStimulus(input logic rdy, input logic [31:0] data, input logic st,
                               input logic fl, input logic br, input logic [31:0] bt,
                               input logic jp, input logic [25:0] jt);
    imem_ready_i    = rdy;
    imem_data_i     = data;
    stall_i         = st;
    flush_i         = fl;
    branch_i        = br;
    branch_target_i = bt;
    jump_i          = jp;
    jump_target_i   = jt;
    @(posedge clk_i);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_i        = 1'b1;
    imem_ready_i = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    branch_i     = 1'b0;
    jump_i       = 1'b0;
    modelReset();
    #1;
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_pc4", pc_plus4_o, 32'd0);
    check("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_req_o}, 32'd1);
    check("post_rst_addr", imem_addr_o, 32'd0);
  endtask

  initial begin
    logic [31:0] rnd_data, rnd_bt;
    logic [25:0] rnd_jt;
    logic        r_rdy, r_st, r_fl, r_br, r_jp;

    doReset();

    // Two back-to-back words from address 0.
    applyStimulus(1'b1, 32'h20080005, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("seq_op0", {26'd0, instr_op_o}, 32'd8);
    check("seq_pc0", pc_o, 32'h0);
    check("seq_addr1", imem_addr_o, 32'h4);
    applyStimulus(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("seq_op1", {26'd0, instr_op_o}, 32'd0);
    check("seq_pc1", pc_o, 32'h4);

    // Three stall cycles as the word at 0x8 arrives.
    applyStimulus(1'b1, 32'h8C010008, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("hold_req", {31'd0, imem_req_o}, 32'd0);
    check("hold_pc", pc_o, 32'h4);
    applyStimulus(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("hold_instr", instr_o, 32'h0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("skid_instr", instr_o, 32'h8C010008);
    check("skid_pc", pc_o, 32'h8);
    check("skid_next_addr", imem_addr_o, 32'hC);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt3", {16'd0, stall_cnt_o}, 32'd3);
`else
    check("stall_cnt3", {16'd0, stall_cnt_o}, 32'd0);
`endif

    // Branch beats a stall and a returning word.
    applyStimulus(1'b1, 32'h11111111, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 26'd0);
    check("br_valid", {31'd0, valid_o}, 32'd0);
    check("br_addr", imem_addr_o, 32'h40);

    // Jump keeps the top nibble of pc_o+4.
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hF0000010, 1'b0, 26'd0);
    applyStimulus(1'b1, 32'h08000004, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("jmp_pc", pc_o, 32'hF0000010);
    applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h0000010);
    check("jmp_addr", imem_addr_o, 32'hF0000040);
    applyStimulus(1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 26'd0);
    check("flush_addr", imem_addr_o, 32'hF0000040);
    check("flush_valid", {31'd0, valid_o}, 32'd0);

    // PC wrap, then an asynchronous reset while holding.
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 26'd0);
    applyStimulus(1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("wrap_pc4", pc_plus4_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);
    applyStimulus(1'b1, 32'h55555555, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check("wrap_hold_req", {31'd0, imem_req_o}, 32'd0);
    doReset();

    for (int i = 0; i < 2000; i++) begin
      rnd_data = $urandom();
      rnd_bt   = $urandom();
      rnd_bt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rnd_bt = 32'hFFFFFFF4;
      rnd_jt = 26'($urandom());
      r_rdy  = ($urandom_range(0, 9) < 7);
      r_st   = ($urandom_range(0, 9) < 3);
      r_fl   = ($urandom_range(0, 49) == 0);
      r_br   = ($urandom_range(0, 19) == 0);
      r_jp   = ($urandom_range(0, 19) == 0);
      applyStimulus(r_rdy, rnd_data, r_st, r_fl, r_br, rnd_bt, r_jp, rnd_jt);
      if ($urandom_range(0, 299) == 0) doReset();
    end

    $display("[TB] random phase complete, failures=%0d", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
